matmul_stream_nxn: RTL

//  Parametrised NxN outer-product matrix multiplier: C = W(NxK) * X(KxN), K chosen per job.

---
 rtl/matmul_pkg.sv | 15 +
 rtl/matmul_stream_nxn_if.sv | 32 +++
 rtl/matmul_stream_nxn_mac_cell.sv | 40 ++++
 rtl/matmul_stream_nxn.sv | 116 +++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the streaming NxN outer-product multiplier.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Accumulator width large enough that KMAX full-scale products never overflow.
  function automatic int unsigned calc_aw(input int unsigned dw, input int unsigned kmax);
    return 2 * dw + $clog2(kmax) + 1;
  endfunction

endpackage

// File: rtl/matmul_stream_nxn_if.sv
// Operand/result stream bundle between feeder, multiplier and sink.
interface matmul_stream_nxn_if #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 4,
  parameter int unsigned AW = 12,
  parameter int unsigned KW = 4,
  parameter int unsigned IW = 4
);
  logic          start;
  logic [KW-1:0] k_len;
  logic          in_valid;
  logic          in_ready;
  logic [N*DW-1:0] w_col;
  logic [N*DW-1:0] x_row;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          busy;
  logic          done;

  modport master (
    output start, k_len, in_valid, w_col, x_row, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, w_col, x_row, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, busy, done
  );
endinterface

// File: rtl/matmul_stream_nxn_mac_cell.sv
// Single multiply-accumulate cell: acc += a*b when enabled, cleared at job start.
module mac_cell #(
  parameter int unsigned DW     = 4,
  parameter int unsigned AW     = 12,
  parameter int unsigned SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [AW-1:0] acc_o
);
  logic [2*DW-1:0] a_ext_c;
  logic [2*DW-1:0] b_ext_c;
  logic [2*DW-1:0] prod_c;
  logic            sfill_c;
  logic [AW-1:0]   prod_ext_c;
  logic [AW-1:0]   acc_q;

  // Operands pre-extended to 2*DW so the low 2*DW product bits are exact for either signedness.
  assign a_ext_c    = (SIGNED != 0) ? {{DW{a_i[DW-1]}}, a_i} : {{DW{1'b0}}, a_i};
  assign b_ext_c    = (SIGNED != 0) ? {{DW{b_i[DW-1]}}, b_i} : {{DW{1'b0}}, b_i};
  assign prod_c     = a_ext_c * b_ext_c;
  assign sfill_c    = (SIGNED != 0) & prod_c[2*DW-1];
  assign prod_ext_c = {{(AW-2*DW){sfill_c}}, prod_c};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + prod_ext_c;
    end
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/matmul_stream_nxn.sv
// NxN outer-product matrix multiplier: accumulates K operand beats, then drains C row-major.
module matmul_stream_nxn
  import matmul_pkg::*;
#(
  parameter int unsigned N      = 3,
  parameter int unsigned DW     = 4,
  parameter int unsigned KMAX   = 8,
  parameter int unsigned SIGNED = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  matmul_stream_nxn_if.slave  bus
);
  localparam int unsigned AW = calc_aw(DW, KMAX);
  localparam int unsigned KW = $clog2(KMAX + 1);
  localparam int unsigned IW = $clog2(N * N);
  localparam int unsigned NN = N * N;
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);
  localparam logic [KW-1:0] KMAX_K   = KW'(KMAX);

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] beat_q, beat_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic          clr_c;
  logic          en_c;
  logic [AW-1:0] acc_c [NN];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    clr_c   = 1'b0;
    en_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && (bus.k_len != '0) && (bus.k_len <= KMAX_K)) begin
          clr_c   = 1'b1;
          k_d     = bus.k_len;
          beat_d  = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          en_c = 1'b1;
          if (beat_q == KW'(k_q - KW'(1))) begin
            beat_d  = '0;
            state_d = DRAIN;
          end else begin
            beat_d = KW'(beat_q + KW'(1));
          end
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = IW'(idx_q + IW'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One MAC per output element; cell (i,j) sees W[i][k] and X[k][j].
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      mac_cell #(
        .DW    (DW),
        .AW    (AW),
        .SIGNED(SIGNED)
      ) u_mac (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(clr_c),
        .en_i (en_c),
        .a_i  (bus.w_col[i*DW +: DW]),
        .b_i  (bus.x_row[j*DW +: DW]),
        .acc_o(acc_c[i*N + j])
      );
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_data  = acc_c[idx_q];
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = (state_q == DRAIN) && (idx_q == LAST_IDX);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
endmodule
